dms_lock_ctrl: RTL and testbench
================================

Name: dms_lock_ctrl

Overview:
Acquisition and lock sequencer for the DMS PFD / charge-pump / VCO loop, clocked by refclk.
- Enables the charge pump after a precharge delay.
- Runs a coarse VCO band search from the PFD up/down activity over fixed sample windows.
- Switches the charge pump from acquisition current to tracking current.
- Declares lock, and detects loss of lock.
- Sits beside dms_top and drives its cp enable, current-select and VCO band inputs.

Parameters:
WIN_LOG2, 6, log2 of the evaluation window length in refclk cycles (64)
BAND_W, 4, VCO band code width
BAND_INIT, 8, band code loaded on reset and on IDLE entry
CNT_TOL, 4, maximum |up-dn| in a window that counts as "balanced"
UNLOCK_TOL, 16, |up-dn| above which a locked loop is declared unlocked
LOCK_WINDOWS, 4, consecutive balanced windows required to assert locked
PRECHARGE_CYC, 32, refclk cycles between cp_en rising and the first window

Ports:
refclk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
start  in  1  level; 1 = run the sequence, 0 = return to IDLE
up  in  1  PFD up pulse, asynchronous to the sampling point
down  in  1  PFD down pulse
cp_en  out  1  charge pump enable
cp_isel  out  2  charge pump current select: 0 off, 3 acquisition, 1 tracking
vco_band  out  BAND_W  coarse VCO band code
locked  out  1  loop locked
cal_done  out  1  band search finished successfully (sticky until IDLE)
cal_fail  out  1  band search hit code 0 or max (sticky until IDLE)

Behaviour:
- Reset (asynchronous, any state): state=IDLE, cp_en=0, cp_isel=0, vco_band=BAND_INIT, locked=0, cal_done=0, cal_fail=0, all counters 0. All outputs are registered.
- Sampling:
  - up and down pass through a 2-flop synchronizer, giving 2 cycles of latency.
  - A sample with up=1, down=0 increments up_cnt.
  - A sample with down=1, up=0 increments dn_cnt.
  - Both 1 or both 0 counts nothing.
  - Counters are WIN_LOG2+1 bits wide and cannot overflow within a window.
- Window:
  - Counts 2^WIN_LOG2 cycles.
  - On the last cycle, diff = up_cnt - dn_cnt (signed, WIN_LOG2+2 bits) is registered as the window result. The decision is acted on the next cycle. The counters restart from 0 on that same cycle.
- FSM:
  - IDLE: all outputs at reset values. start=1 -> PRECHARGE.
  - PRECHARGE: cp_en=1, cp_isel=3. After PRECHARGE_CYC cycles -> SEARCH, with the window restarted.
  - SEARCH, per window result:
    - diff>CNT_TOL (VCO slow): vco_band+1.
    - diff<-CNT_TOL: vco_band-1.
    - |diff|<=CNT_TOL: cal_done=1 -> ACQ.
    - A step in the opposite direction to the previous step also ends the search: apply that step, cal_done=1 -> ACQ.
    - A step that would go beyond 0 or 2^BAND_W-1 does not change the band: cal_fail=1 -> FAIL.
    - The window immediately after any band change is discarded (settle).
  - ACQ: cp_isel=3. Count consecutive windows with |diff|<=CNT_TOL; any other window clears the count. When the count reaches LOCK_WINDOWS -> LOCKED.
  - LOCKED: locked=1, cp_isel=1. A window with |diff|>UNLOCK_TOL -> ACQ with locked=0 and cp_isel=3 on the next cycle. vco_band is not changed.
  - FAIL: cp_en=0, cp_isel=0, cal_fail=1. Remains here until start=0.
- start=0 in any state: IDLE on the next cycle. vco_band reloads BAND_INIT; cal_done and cal_fail clear.
- up and down are never counted in IDLE or PRECHARGE.

Decomposition:
- Package dms_ctrl_pkg:
  - state enum {IDLE, PRECHARGE, SEARCH, ACQ, LOCKED, FAIL}
  - ISEL_OFF=2'd0, ISEL_TRK=2'd1, ISEL_ACQ=2'd3
  - window diff width function
- Sub-module dms_pd_window: synchronizer, up/down counters, window counter, and signed diff output with a valid strobe.
- dms_lock_ctrl holds the FSM, the band register and the lock counter.

Test Plan:
1. Reset mid-LOCKED (rst pulse of 1 ns) -> outputs immediately 0 / vco_band=8, with no refclk edge required.
2. start=1, up held 1 for every window -> cp_en at cycle 1; band steps 8→9→…→15, one step every 128 cycles (change window plus settle window); then cal_fail=1, cp_en=0 in FAIL.
3. start=1, up dominant for 2 band steps, then down dominant -> band 8→9→10→9, cal_done=1, state ACQ.
4. Balanced up/down (diff=2) from the first window -> cal_done=1, band stays 8; locked=1 after 4 further windows (1 decision cycle later); cp_isel 3→1.
5. From LOCKED, one window with diff=20 -> locked=0, cp_isel=3; a window with diff=10 leaves locked=1.
6. up and down both held 1 for a whole window -> diff=0, no counts. start dropped in SEARCH -> IDLE next cycle, band reloaded to 8, cal flags cleared.

Source files
------------

// File: rtl/dms_ctrl_pkg.sv
// rtl/dms_ctrl_pkg.sv - shared types and constants for the DMS lock sequencer
package dms_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        SEARCH,
        ACQ,
        LOCKED,
        FAIL
    } state_t;

    localparam logic [1:0] ISEL_OFF = 2'd0;
    localparam logic [1:0] ISEL_TRK = 2'd1;
    localparam logic [1:0] ISEL_ACQ = 2'd3;

    // Signed up-minus-down result: counters are win_log2+1 bits, plus a sign bit.
    function automatic int diff_width(input int win_log2);
        return win_log2 + 2;
    endfunction

endpackage

// File: rtl/dms_pd_window.sv
// rtl/dms_pd_window.sv - PFD up/down synchronizer, windowed counters and signed diff strobe
module dms_pd_window
    import dms_ctrl_pkg::*;
#(
    parameter int WIN_LOG2 = 6
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     en_i,
    input  logic                                     up_i,
    input  logic                                     down_i,
    output logic signed [diff_width(WIN_LOG2)-1:0]   diff_o,
    output logic                                     valid_o
);

    localparam int DW = diff_width(WIN_LOG2);
    localparam int CW = WIN_LOG2 + 1;

    logic [1:0]           up_sync_q;
    logic [1:0]           dn_sync_q;
    logic [WIN_LOG2-1:0]  win_cnt_q, win_cnt_d;
    logic [CW-1:0]        up_cnt_q, up_cnt_d;
    logic [CW-1:0]        dn_cnt_q, dn_cnt_d;
    logic signed [DW-1:0] diff_q, diff_d;
    logic                 valid_q, valid_d;

    logic                 up_inc;
    logic                 dn_inc;
    logic                 win_last;
    logic [CW-1:0]        up_tot;
    logic [CW-1:0]        dn_tot;

    assign up_inc   = up_sync_q[1] & ~dn_sync_q[1];
    assign dn_inc   = dn_sync_q[1] & ~up_sync_q[1];
    assign win_last = &win_cnt_q;
    assign up_tot   = up_cnt_q + CW'(up_inc);
    assign dn_tot   = dn_cnt_q + CW'(dn_inc);

    // The last sample of a window is folded into the result, so every window spans 2^WIN_LOG2 samples.
    always_comb begin
        win_cnt_d = '0;
        up_cnt_d  = '0;
        dn_cnt_d  = '0;
        diff_d    = diff_q;
        valid_d   = 1'b0;
        if (en_i) begin
            win_cnt_d = win_cnt_q + WIN_LOG2'(1);
            if (win_last) begin
                diff_d  = $signed({1'b0, up_tot}) - $signed({1'b0, dn_tot});
                valid_d = 1'b1;
            end else begin
                up_cnt_d = up_tot;
                dn_cnt_d = dn_tot;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            up_sync_q <= '0;
            dn_sync_q <= '0;
            win_cnt_q <= '0;
            up_cnt_q  <= '0;
            dn_cnt_q  <= '0;
            diff_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            up_sync_q <= {up_sync_q[0], up_i};
            dn_sync_q <= {dn_sync_q[0], down_i};
            win_cnt_q <= win_cnt_d;
            up_cnt_q  <= up_cnt_d;
            dn_cnt_q  <= dn_cnt_d;
            diff_q    <= diff_d;
            valid_q   <= valid_d;
        end
    end

    assign diff_o  = diff_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/dms_lock_ctrl.sv
// rtl/dms_lock_ctrl.sv - precharge, VCO band search, acquisition and lock supervision FSM
module dms_lock_ctrl
    import dms_ctrl_pkg::*;
#(
    parameter int WIN_LOG2      = 6,
    parameter int BAND_W        = 4,
    parameter int BAND_INIT     = 8,
    parameter int CNT_TOL       = 4,
    parameter int UNLOCK_TOL    = 16,
    parameter int LOCK_WINDOWS  = 4,
    parameter int PRECHARGE_CYC = 32
) (
    input  logic              refclk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              up_i,
    input  logic              down_i,
    output logic              cp_en_o,
    output logic [1:0]        cp_isel_o,
    output logic [BAND_W-1:0] vco_band_o,
    output logic              locked_o,
    output logic              cal_done_o,
    output logic              cal_fail_o
);

    localparam int DW     = diff_width(WIN_LOG2);
    localparam int PRE_W  = (PRECHARGE_CYC > 1) ? $clog2(PRECHARGE_CYC) : 1;
    localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic signed [DW-1:0] TOL_P = DW'(CNT_TOL);
    localparam logic signed [DW-1:0] TOL_N = -TOL_P;
    localparam logic signed [DW-1:0] UNL_P = DW'(UNLOCK_TOL);
    localparam logic signed [DW-1:0] UNL_N = -UNL_P;
    localparam logic [BAND_W-1:0]    BAND_RST = BAND_W'(BAND_INIT);

    state_t               state_q, state_d;
    logic [BAND_W-1:0]    band_q, band_d;
    logic [PRE_W-1:0]     pre_cnt_q, pre_cnt_d;
    logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic                 settle_q, settle_d;
    logic                 last_up_q, last_up_d;
    logic                 last_dn_q, last_dn_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;
    logic                 cp_en_q, cp_en_d;
    logic [1:0]           isel_q, isel_d;
    logic                 locked_q, locked_d;

    logic                 win_en;
    logic                 win_valid;
    logic signed [DW-1:0] win_diff;
    logic                 go_up;
    logic                 go_dn;
    logic                 balanced;
    logic                 unlock;

    assign win_en = (state_q == SEARCH) || (state_q == ACQ) || (state_q == LOCKED);

    dms_pd_window #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_pd_window (
        .clk_i   (refclk_i),
        .rst_i   (rst_i),
        .en_i    (win_en),
        .up_i    (up_i),
        .down_i  (down_i),
        .diff_o  (win_diff),
        .valid_o (win_valid)
    );

    // Positive diff means the PFD saw more up pulses: the VCO is slow.
    assign go_up    = win_diff > TOL_P;
    assign go_dn    = win_diff < TOL_N;
    assign balanced = !go_up && !go_dn;
    assign unlock   = (win_diff > UNL_P) || (win_diff < UNL_N);

    always_comb begin
        state_d    = state_q;
        band_d     = band_q;
        pre_cnt_d  = pre_cnt_q;
        lock_cnt_d = lock_cnt_q;
        settle_d   = settle_q;
        last_up_d  = last_up_q;
        last_dn_d  = last_dn_q;
        done_d     = done_q;
        fail_d     = fail_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = PRECHARGE;
                    pre_cnt_d = '0;
                end
            end
            PRECHARGE: begin
                if (pre_cnt_q == PRE_W'(PRECHARGE_CYC - 1)) begin
                    state_d   = SEARCH;
                    settle_d  = 1'b0;
                    last_up_d = 1'b0;
                    last_dn_d = 1'b0;
                end else begin
                    pre_cnt_d = pre_cnt_q + PRE_W'(1);
                end
            end
            SEARCH: begin
                if (win_valid) begin
                    if (settle_q) begin
                        settle_d = 1'b0;
                    end else if (balanced) begin
                        done_d     = 1'b1;
                        lock_cnt_d = '0;
                        state_d    = ACQ;
                    end else if ((go_up && (band_q == '1)) || (go_dn && (band_q == '0))) begin
                        fail_d  = 1'b1;
                        state_d = FAIL;
                    end else begin
                        band_d    = go_up ? band_q + BAND_W'(1) : band_q - BAND_W'(1);
                        settle_d  = 1'b1;
                        last_up_d = go_up;
                        last_dn_d = go_dn;
                        // A reversal means the target lies between the last two bands.
                        if ((go_up && last_dn_q) || (go_dn && last_up_q)) begin
                            done_d     = 1'b1;
                            lock_cnt_d = '0;
                            state_d    = ACQ;
                        end
                    end
                end
            end
            ACQ: begin
                if (win_valid) begin
                    if (settle_q) begin
                        settle_d = 1'b0;
                    end else if (balanced) begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                        if (lock_cnt_q == LOCK_W'(LOCK_WINDOWS - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (win_valid && unlock) begin
                    lock_cnt_d = '0;
                    state_d    = ACQ;
                end
            end
            FAIL: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!start_i) begin
            state_d    = IDLE;
            band_d     = BAND_RST;
            pre_cnt_d  = '0;
            lock_cnt_d = '0;
            settle_d   = 1'b0;
            last_up_d  = 1'b0;
            last_dn_d  = 1'b0;
            done_d     = 1'b0;
            fail_d     = 1'b0;
        end

        cp_en_d  = (state_d == PRECHARGE) || (state_d == SEARCH) ||
                   (state_d == ACQ) || (state_d == LOCKED);
        locked_d = (state_d == LOCKED);
        unique case (state_d)
            PRECHARGE, SEARCH, ACQ: isel_d = ISEL_ACQ;
            LOCKED:                 isel_d = ISEL_TRK;
            default:                isel_d = ISEL_OFF;
        endcase
    end

    always_ff @(posedge refclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            band_q     <= BAND_RST;
            pre_cnt_q  <= '0;
            lock_cnt_q <= '0;
            settle_q   <= 1'b0;
            last_up_q  <= 1'b0;
            last_dn_q  <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            cp_en_q    <= 1'b0;
            isel_q     <= ISEL_OFF;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            band_q     <= band_d;
            pre_cnt_q  <= pre_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            settle_q   <= settle_d;
            last_up_q  <= last_up_d;
            last_dn_q  <= last_dn_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            cp_en_q    <= cp_en_d;
            isel_q     <= isel_d;
            locked_q   <= locked_d;
        end
    end

    assign cp_en_o    = cp_en_q;
    assign cp_isel_o  = isel_q;
    assign vco_band_o = band_q;
    assign locked_o   = locked_q;
    assign cal_done_o = done_q;
    assign cal_fail_o = fail_q;

endmodule

// File: tb/tb_dms_lock_ctrl.sv
// tb/tb_dms_lock_ctrl.sv - randomized bench for dms_lock_ctrl against a behavioural loop model
module tb_dms_lock_ctrl;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic       up     = 1'b0;
    logic       down   = 1'b0;
    logic       cp_en;
    logic [1:0] cp_isel;
    logic [3:0] vco_band;
    logic       locked;
    logic       cal_done;
    logic       cal_fail;
    logic [9:0] dut_outs;

    dms_lock_ctrl dut (
        .refclk_i   (refclk),
        .rst_i      (rst),
        .start_i    (start),
        .up_i       (up),
        .down_i     (down),
        .cp_en_o    (cp_en),
        .cp_isel_o  (cp_isel),
        .vco_band_o (vco_band),
        .locked_o   (locked),
        .cal_done_o (cal_done),
        .cal_fail_o (cal_fail)
    );

    always #5 refclk = ~refclk;

    assign dut_outs = {cp_en, cp_isel, vco_band, locked, cal_done, cal_fail};

    int n_checks = 0;
    int n_fail   = 0;

    localparam int P_IDLE = 0, P_PRE = 1, P_SEARCH = 2, P_ACQ = 3, P_LOCKED = 4, P_FAIL = 5;

    int       m_ph, m_band, m_pre, m_lock, m_win, m_ups, m_dns, m_pdiff, m_lastdir;
    bit       m_pend, m_settle, m_done, m_fail;
    bit [1:0] m_hist[$];
    bit       pat_u[64];
    bit       pat_d[64];
    int       tick = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_band = 8; m_pre = 0; m_lock = 0;
        m_win = 0; m_ups = 0; m_dns = 0; m_pdiff = 0; m_lastdir = 0;
        m_pend = 0; m_settle = 0; m_done = 0; m_fail = 0;
        m_hist.delete();
        m_hist.push_back(2'b00);
        m_hist.push_back(2'b00);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One refclk edge of the loop as described: PFD samples land two edges late,
    // window results arrive one edge after the window closes.
    task automatic model_edge(input bit u, input bit d, input bit s);
        bit cu, cd, have, run_old;
        int hd, dir;
        m_hist.push_back({u, d});
        cu = m_hist[0][1];
        cd = m_hist[0][0];
        void'(m_hist.pop_front());
        have    = m_pend;
        hd      = m_pdiff;
        run_old = (m_ph == P_SEARCH) || (m_ph == P_ACQ) || (m_ph == P_LOCKED);
        if (run_old) begin
            m_win++;
            if (cu && !cd) m_ups++;
            if (cd && !cu) m_dns++;
            m_pend = (m_win == 64);
            if (m_win == 64) begin
                m_pdiff = m_ups - m_dns;
                m_win = 0; m_ups = 0; m_dns = 0;
            end
        end else begin
            m_win = 0; m_ups = 0; m_dns = 0; m_pend = 0;
        end

        if (!s) begin
            m_ph = P_IDLE; m_band = 8; m_done = 0; m_fail = 0;
            m_lock = 0; m_settle = 0; m_lastdir = 0; m_pre = 0;
        end else begin
            case (m_ph)
                P_IDLE: begin m_ph = P_PRE; m_pre = 0; end
                P_PRE: begin
                    m_pre++;
                    if (m_pre == 32) begin m_ph = P_SEARCH; m_settle = 0; m_lastdir = 0; end
                end
                P_SEARCH: if (have) begin
                    if (m_settle) m_settle = 0;
                    else begin
                        dir = (hd > 4) ? 1 : ((hd < -4) ? -1 : 0);
                        if (dir == 0) begin
                            m_done = 1; m_ph = P_ACQ; m_lock = 0;
                        end else if (m_band + dir < 0 || m_band + dir > 15) begin
                            m_fail = 1; m_ph = P_FAIL;
                        end else begin
                            m_band += dir; m_settle = 1;
                            if (m_lastdir == -dir) begin m_done = 1; m_ph = P_ACQ; m_lock = 0; end
                            m_lastdir = dir;
                        end
                    end
                end
                P_ACQ: if (have) begin
                    if (m_settle) m_settle = 0;
                    else if (iabs(hd) <= 4) begin
                        m_lock++;
                        if (m_lock == 4) m_ph = P_LOCKED;
                    end else m_lock = 0;
                end
                P_LOCKED: if (have && iabs(hd) > 16) begin m_ph = P_ACQ; m_lock = 0; end
                default: ;
            endcase
        end
    endtask

    function automatic logic [9:0] model_outs();
        logic       en;
        logic [1:0] isel;
        en   = (m_ph != P_IDLE) && (m_ph != P_FAIL);
        isel = (m_ph == P_LOCKED) ? 2'd1 : (en ? 2'd3 : 2'd0);
        return {en, isel, 4'(m_band), (m_ph == P_LOCKED), m_done, m_fail};
    endfunction

    // A 64-periodic pattern gives every 64-cycle window exactly nu-nd, whatever its phase.
    task automatic make_pattern(input int nu, input int nd, input bit all_both);
        int j;
        bit t;
        for (int i = 0; i < 64; i++) begin
            if (all_both) begin
                pat_u[i] = 1'b1; pat_d[i] = 1'b1;
            end else if (i < nu) begin
                pat_u[i] = 1'b1; pat_d[i] = 1'b0;
            end else if (i < nu + nd) begin
                pat_u[i] = 1'b0; pat_d[i] = 1'b1;
            end else begin
                t = 1'($urandom_range(1, 0));
                pat_u[i] = t; pat_d[i] = t;
            end
        end
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = pat_u[i]; pat_u[i] = pat_u[j]; pat_u[j] = t;
            t = pat_d[i]; pat_d[i] = pat_d[j]; pat_d[j] = t;
        end
    endtask

    task automatic cycle();
        up   = pat_u[tick % 64];
        down = pat_d[tick % 64];
        tick++;
        @(posedge refclk);
        model_edge(up, down, start);
        @(negedge refclk);
        chk("outs", 32'(dut_outs), 32'(model_outs()));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        model_reset();
        make_pattern(0, 0, 1'b0);
        repeat (2) @(negedge refclk);
        chk("rst_state", 32'(dut_outs), 32'({1'b0, 2'd0, 4'd8, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;

        // up always: climb to band 15 then fail
        make_pattern(64, 0, 1'b0);
        start = 1'b1;
        run(1);
        chk("t2_cpen_c1", 32'(cp_en), 32'd1);
        run(1100);
        chk("t2_band", 32'(vco_band), 32'd15);
        chk("t2_fail", 32'(cal_fail), 32'd1);
        chk("t2_cpen", 32'(cp_en), 32'd0);
        start = 1'b0;
        run(1);
        chk("idle_band", 32'(vco_band), 32'd8);
        chk("idle_fail", 32'(cal_fail), 32'd0);

        // two up steps then down: reversal ends search at 9
        make_pattern(20, 5, 1'b0);
        start = 1'b1;
        run(260);
        make_pattern(5, 20, 1'b0);
        run(110);
        chk("t3_band", 32'(vco_band), 32'd9);
        chk("t3_done", 32'(cal_done), 32'd1);
        chk("t3_isel", 32'(cp_isel), 32'd3);
        start = 1'b0;
        run(2);

        // balanced diff=2: done at first window, lock after four more
        make_pattern(10, 8, 1'b0);
        start = 1'b1;
        run(400);
        chk("t4_locked", 32'(locked), 32'd1);
        chk("t4_isel", 32'(cp_isel), 32'd1);
        chk("t4_band", 32'(vco_band), 32'd8);

        // asynchronous reset while locked, no clock edge
        #1 rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("arst_outs", 32'(dut_outs), 32'({1'b0, 2'd0, 4'd8, 1'b0, 1'b0, 1'b0}));
        run(400);
        chk("relock", 32'(locked), 32'd1);

        make_pattern(15, 5, 1'b0);
        run(200);
        chk("t5_keep", 32'(locked), 32'd1);
        make_pattern(22, 2, 1'b0);
        run(140);
        chk("t5_drop", 32'(locked), 32'd0);
        chk("t5_isel", 32'(cp_isel), 32'd3);
        start = 1'b0;
        run(2);

        // both held: nothing counted, balanced
        make_pattern(0, 0, 1'b1);
        start = 1'b1;
        run(100);
        chk("t6_done", 32'(cal_done), 32'd1);
        chk("t6_band", 32'(vco_band), 32'd8);
        start = 1'b0;
        run(2);

        // drop start mid-search
        make_pattern(64, 0, 1'b0);
        start = 1'b1;
        run(120);
        chk("t6_step", 32'(vco_band), 32'd9);
        start = 1'b0;
        run(1);
        chk("t6_idle", 32'(dut_outs), 32'({1'b0, 2'd0, 4'd8, 1'b0, 1'b0, 1'b0}));

        // down always: descend to band 0 then fail
        make_pattern(0, 64, 1'b0);
        start = 1'b1;
        run(1200);
        chk("dn_band", 32'(vco_band), 32'd0);
        chk("dn_fail", 32'(cal_fail), 32'd1);
        start = 1'b0;
        run(2);

        for (int r = 0; r < 6; r++) begin
            start = 1'b1;
            for (int seg = 0; seg < int'($urandom_range(8, 3)); seg++) begin
                int nu, nd;
                nu = int'($urandom_range(40, 0));
                nd = int'($urandom_range(64 - nu, 0));
                make_pattern(nu, nd, 1'b0);
                run(int'($urandom_range(200, 40)));
            end
            start = 1'b0;
            run(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
